// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises command words from MOSI and serialises memory read data onto MISO.
// Optional abort reporting output frame_err is built when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave_if #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   MOSI,
   input  logic                   SS_n,
   input  logic                   tx_valid,
   input  logic [ADDR_SIZE-1:0]   tx_data,
   output logic                   MISO,
   output logic                   rx_valid,
   output logic [ADDR_SIZE+1:0]   rx_data
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic                   frame_err
`endif
);

   localparam int WORD_W = ADDR_SIZE + 2;

   // bit_cnt continues past the word length to sequence the read-data response
   localparam logic [3:0] CNT_DONE = 4'(WORD_W);
   localparam logic [3:0] CNT_WAIT = CNT_DONE + 4'd1;
   localparam logic [3:0] CNT_TX   = CNT_DONE + 4'd2;
   localparam logic [3:0] CNT_END  = CNT_DONE + 4'd3;
   localparam logic [2:0] TX_LAST  = 3'(ADDR_SIZE - 1);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [3:0]             bit_cnt;
   logic [WORD_W-1:0]      rx_shift;
   logic [ADDR_SIZE-1:0]   tx_shift;
   logic [2:0]             tx_cnt;
   logic                   rd_addr_flag;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (SS_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)            state_d = WRITE;
               else if (rd_addr_flag) state_d = READ_DATA;
               else                  state_d = READ_ADD;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         tx_cnt       <= '0;
         rd_addr_flag <= 1'b0;
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         MISO         <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err    <= 1'b0;
`endif
      end else if (SS_n) begin
         bit_cnt  <= '0;
         tx_cnt   <= '0;
         rx_valid <= 1'b0;
         MISO     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err <= (state_q != IDLE) && (bit_cnt < CNT_DONE);
`endif
      end else begin
         rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         case (state_q)
            CHK_CMD: begin
               rx_shift <= {rx_shift[WORD_W-2:0], MOSI};
               bit_cnt  <= 4'd1;
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (bit_cnt < CNT_DONE) begin
                  rx_shift <= {rx_shift[WORD_W-2:0], MOSI};
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == CNT_DONE - 4'd1) begin
                     rx_data  <= {rx_shift[WORD_W-2:0], MOSI};
                     rx_valid <= 1'b1;
                     if (state_q == READ_ADD)  rd_addr_flag <= 1'b1;
                     if (state_q == READ_DATA) rd_addr_flag <= 1'b0;
                  end
               end else if (state_q == READ_DATA) begin
                  // one guard edge lets the memory see rx_valid before tx_valid is trusted
                  case (bit_cnt)
                     CNT_DONE: bit_cnt <= CNT_WAIT;
                     CNT_WAIT: begin
                        if (tx_valid) begin
                           MISO     <= tx_data[ADDR_SIZE-1];
                           tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                           tx_cnt   <= '0;
                           bit_cnt  <= CNT_TX;
                        end
                     end
                     CNT_TX: begin
                        if (tx_cnt == TX_LAST) begin
                           MISO    <= 1'b0;
                           bit_cnt <= CNT_END;
                        end else begin
                           MISO     <= tx_shift[ADDR_SIZE-1];
                           tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                           tx_cnt   <= tx_cnt + 3'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial-to-parallel SPI slave front end. It sits between the external SPI master and the on-chip memory block. It deserialises 10-bit MOSI command words into a parallel word plus a `rx_valid` strobe, and serialises the memory's 8-bit read data back out on MISO. It owns the write / read-address / read-data framing state machine, including the flag that tracks whether a read address is pending.

## Interface
- `ADDR_SIZE`, default 8: data/address width. The command word is `ADDR_SIZE+2` bits.
- `CLK`  in  1: SPI serial clock. All logic runs on the rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `MOSI`  in  1: serial data from the master, MSB first, sampled on the rising edge of `CLK`.
- `SS_n`  in  1: active-low slave select. A high level ends or aborts the frame.
- `tx_valid`  in  1: memory read data is valid. It may stay high (sticky).
- `tx_data`  in  ADDR_SIZE: memory read data.
- `MISO`  out  1: registered serial data to the master, MSB first.
- `rx_valid`  out  1: one-cycle strobe; `rx_data` holds a complete word.
- `rx_data`  out  ADDR_SIZE+2: received word. Bits [9:8] are the command, bits [7:0] the payload.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal state: 4-bit bit counter, 10-bit RX shift register, 8-bit TX shift register, 3-bit TX counter, and `rd_addr_flag` (reset 0).
- IDLE -> CHK_CMD on an edge with `SS_n`=0. MOSI is ignored on that edge.
- In CHK_CMD, the MOSI bit is command bit 9. It is shifted in, and the counter is set to 1. The next state is:
  - bit 9 = 0 -> WRITE;
  - bit 9 = 1 and `rd_addr_flag`=0 -> READ_ADD;
  - bit 9 = 1 and `rd_addr_flag`=1 -> READ_DATA.
- WRITE, READ_ADD and READ_DATA each shift in 9 more bits.
- On the edge that samples the 10th bit: `rx_data` <= {shift[8:0], MOSI} and `rx_valid` <= 1.
- `rx_valid` is cleared on the next edge. `rx_data` holds its value until the next word completes.
- Further MOSI bits in the same frame are ignored.
- `rd_addr_flag` is set when a READ_ADD word completes and cleared when a READ_DATA word completes. WRITE never changes it.
- READ_DATA response:
  - After the word completes, the slave waits at least 2 edges so the memory can act on `rx_valid`. The stale sticky `tx_valid` is therefore never used.
  - On the first edge from the 2nd post-word edge onward with `tx_valid`=1: load `tx_data` and set MISO <= `tx_data`[7].
  - The following 7 edges drive bits 6..0.
  - After that, MISO <= 0 and the slave holds until `SS_n` goes high.
- MISO is 0 whenever the slave is not shifting out read data.
- `SS_n`=1 on any edge, in any state:
  - state <= IDLE; counters cleared; `rx_valid` <= 0; MISO <= 0;
  - a partial word is discarded with no strobe;
  - `rd_addr_flag` and `rx_data` are kept.
- Reset (RST=0): state IDLE, `rx_valid`=0, `rx_data`=0, MISO=0, `rd_addr_flag`=0, all counters and shift registers 0.

## Timing
- E0 is the edge with `SS_n` low that enters CHK_CMD.
- E1..E10 sample bits 9..0.
- `rx_valid` is high during the cycle after E10, one cycle only.
- The memory samples the strobe at E11. The slave loads `tx_data` at E12 at the earliest.
- MISO bit 7 is valid after E12; bit 0 is valid after E19.
- A full read-data frame needs `SS_n` low for at least 20 rising edges. A write or read-address frame needs 11.
- A new frame may start on the edge right after `SS_n` returns low. No idle gap is required beyond one high sample.

## Configuration
- `SPI_SLAVE_FRAME_ERR_EN`:
  - Defined: adds output `frame_err` (1 bit, reset 0). It pulses high for one cycle when `SS_n` rises after CHK_CMD was entered but before the 10th bit was sampled.
  - Not defined: the port and its logic are absent. Aborts are silent.

## Test plan
- Reset mid-frame: assert RST after 5 bits -> all outputs 0 immediately and state IDLE. A following full frame works normally.
- Write address: send 10'b00_1010_0101 -> `rx_data`=0x0A5, `rx_valid` high exactly one cycle after E10, `rd_addr_flag` stays 0.
- Write data: send 10'b01_0011_1100 -> `rx_data`=0x13C with a one-cycle `rx_valid`. MISO stays 0 throughout.
- Read address: send 10'b10_0000_0111 -> `rx_data`=0x207 and `rd_addr_flag`=1. Then read data: send 10'b11_0000_0000 with the memory model returning 0xC3 -> MISO carries 1,1,0,0,0,0,1,1 after E12..E19, and `rd_addr_flag`=0.
- Stale `tx_valid`: hold `tx_valid`=1 with `tx_data`=0xFF before the read-data word, and have the memory update it to 0x5A at E11 -> the slave shifts out 0x5A, not 0xFF.
- Abort: raise `SS_n` after 6 bits -> no `rx_valid`, state IDLE, `rx_data` unchanged. With `SPI_SLAVE_FRAME_ERR_EN` defined, `frame_err` pulses once.
